// File: rtl/apb_regbank_completer_if.sv
// APB bus bundle between a requester (master) and the register-bank completer (slave).
interface apb_regbank_completer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [2:0]            pprot;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_regbank_completer.sv
// APB completer with NUM_REGS word registers, fixed wait states, byte-strobe writes
// and error responses for out-of-range addresses and unprivileged writes.
module apb_regbank_completer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                  pclk,
  input  logic                  presetn,
  apb_regbank_completer_if.slave apb
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam int          IDXW = ADDR_WIDTH - 2;
  localparam int          RW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);
  localparam int unsigned SW   = STRB_WIDTH;
  localparam int unsigned NR   = NUM_REGS;

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic [IDXW-1:0]       r_idx;
  logic                  r_write;
  logic                  r_priv;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_strb;
  logic                  r_pready;
  logic                  r_pslverr;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  w_setup;
  logic                  w_capture;
  logic [IDXW-1:0]       w_idx;
  logic                  w_write;
  logic                  w_priv;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [DATA_WIDTH-1:0] w_resp;
  logic                  w_unused;

  assign w_setup   = apb.psel & ~apb.penable;
  // A setup seen during the completion cycle is not a legal restart; it is ignored.
  assign w_capture = w_setup & ~((r_state == S_ACCESS) & r_pready);
  assign w_unused  = ^{apb.paddr[1:0], apb.pprot[2:1]};

  // Decode from the live bus when capturing (needed for zero wait states), else from the capture.
  always_comb begin
    w_idx   = w_capture ? apb.paddr[ADDR_WIDTH-1:2] : r_idx;
    w_write = w_capture ? apb.pwrite : r_write;
    w_priv  = w_capture ? apb.pprot[0] : r_priv;
    w_err   = (int'(w_idx) >= NUM_REGS) | (w_write & ~w_priv);
    w_rdata = r_regs[w_idx[RW-1:0]];
    w_resp  = (w_err | w_write) ? '0 : w_rdata;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_write   <= 1'b0;
      r_priv    <= 1'b0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      for (int unsigned i = 0; i < NR; i++) r_regs[i] <= '0;
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      case (r_state)
        S_ACCESS: begin
          if (r_pready) begin
            if (w_write && !w_err) begin
              for (int unsigned i = 0; i < SW; i++)
                if (r_strb[i]) r_regs[w_idx[RW-1:0]][8*i +: 8] <= r_wdata[8*i +: 8];
            end
            r_state <= S_DONE;
          end else if (!apb.psel) begin
            r_state <= S_IDLE;
          end else if (apb.penable) begin
            if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= w_resp;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_capture) begin
        r_state <= S_ACCESS;
        r_cnt   <= WS;
        r_idx   <= w_idx;
        r_write <= apb.pwrite;
        r_priv  <= apb.pprot[0];
        r_wdata <= apb.pwdata;
        r_strb  <= apb.pstrb;
        if (WS == 4'd0) begin
          r_pready  <= 1'b1;
          r_pslverr <= w_err;
          r_prdata  <= w_resp;
        end
      end
    end
  end

  assign apb.pready  = r_pready;
  assign apb.pslverr = r_pslverr;
  assign apb.prdata  = r_prdata;
endmodule

// File: tb/tb_apb_regbank_completer.sv
// Bench for apb_regbank_completer: two instances (1 and 0 wait states) driven by
// directed and random APB traffic, checked every cycle against a transaction-level model.
module tb_apb_regbank_completer;
  logic pclk = 1'b0;
  logic presetn;
  always #5 pclk = ~pclk;

  apb_regbank_completer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus_a ();
  apb_regbank_completer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus_b ();

  apb_regbank_completer #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(1))
    dut_ws1 (.pclk(pclk), .presetn(presetn), .apb(bus_a));
  apb_regbank_completer #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(0))
    dut_ws0 (.pclk(pclk), .presetn(presetn), .apb(bus_b));

  logic        sel [2];
  logic        en  [2];
  logic        wr  [2];
  logic [7:0]  addr[2];
  logic [31:0] wdat[2];
  logic [3:0]  strb[2];
  logic [2:0]  prot[2];

  assign bus_a.psel = sel[0];  assign bus_a.penable = en[0];  assign bus_a.pwrite = wr[0];
  assign bus_a.paddr = addr[0]; assign bus_a.pwdata = wdat[0]; assign bus_a.pstrb = strb[0];
  assign bus_a.pprot = prot[0];
  assign bus_b.psel = sel[1];  assign bus_b.penable = en[1];  assign bus_b.pwrite = wr[1];
  assign bus_b.paddr = addr[1]; assign bus_b.pwdata = wdat[1]; assign bus_b.pstrb = strb[1];
  assign bus_b.pprot = prot[1];

  logic        rdy [2];
  logic        errv[2];
  logic [31:0] rdv [2];
  assign rdy[0] = bus_a.pready; assign errv[0] = bus_a.pslverr; assign rdv[0] = bus_a.prdata;
  assign rdy[1] = bus_b.pready; assign errv[1] = bus_b.pslverr; assign rdv[1] = bus_b.prdata;

  // Transaction-level model: register contents per instance and expected outputs this cycle.
  logic [31:0] mem [2][16];
  logic        exp_rdy[2];
  logic        exp_err[2];
  logic [31:0] exp_rd [2];
  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge pclk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("pready[%0d]", d), 32'(rdy[d]), 32'(exp_rdy[d]));
        chk($sformatf("pslverr[%0d]", d), 32'(errv[d]), 32'(exp_err[d]));
        chk($sformatf("prdata[%0d]", d), rdv[d], exp_rd[d]);
      end
    end
  end

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) mem[d][i] = '0;
  endtask

  // Advance one cycle; outputs are expected idle unless the caller says otherwise.
  task automatic cyc();
    @(posedge pclk);
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_rdy[d] = 1'b0; exp_err[d] = 1'b0; exp_rd[d] = '0;
    end
  endtask

  task automatic idle();
    cyc();
    for (int d = 0; d < 2; d++) begin sel[d] = 1'b0; en[d] = 1'b0; end
  endtask

  task automatic partial(input int d, input logic [7:0] a, input logic w, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr);
    cyc();
    sel[d] = 1'b1; en[d] = 1'b0; addr[d] = a; wr[d] = w; wdat[d] = wd; strb[d] = st; prot[d] = pr;
  endtask

  task automatic xfer(input int d, input logic [7:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr, input bit scramble,
                      output logic [31:0] got_rd, output logic got_err);
    int          ws;
    int          idx;
    logic        err;
    logic [31:0] er;
    ws  = (d == 0) ? 1 : 0;
    idx = int'(a[7:2]);
    err = (idx >= 16) || (w && !pr[0]);
    er  = (err || w) ? 32'h0 : mem[d][idx[3:0]];
    partial(d, a, w, wd, st, pr);
    for (int k = 1; k <= ws + 1; k++) begin
      cyc();
      en[d] = 1'b1;
      if (scramble) begin
        addr[d] = 8'($urandom); wr[d] = 1'($urandom); wdat[d] = $urandom;
        strb[d] = 4'($urandom); prot[d] = 3'($urandom);
      end
      if (k == ws + 1) begin
        exp_rdy[d] = 1'b1; exp_err[d] = err; exp_rd[d] = er;
      end
    end
    #2;
    got_rd  = rdv[d];
    got_err = errv[d];
    if (w && !err)
      for (int b = 0; b < 4; b++)
        if (st[b]) mem[d][idx[3:0]][8*b +: 8] = wd[8*b +: 8];
  endtask

  logic [31:0] g;
  logic        ge;
  int          rd_d, prev_d;
  logic [7:0]  ra;
  logic        rw;
  logic [2:0]  rp;

  initial begin
    presetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      sel[d] = 1'b0; en[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdat[d] = '0; strb[d] = '0; prot[d] = '0;
      exp_rdy[d] = 1'b0; exp_err[d] = 1'b0; exp_rd[d] = '0;
    end
    clear_model();
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b1;
    chk_on = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_pready", 32'(rdy[d]), 32'h0);
      chk("reset_prdata", rdv[d], 32'h0);
    end

    // Read of index 3 after reset.
    xfer(0, 8'h0C, 1'b0, 32'h0, 4'hF, 3'b001, 1'b0, g, ge);
    chk("rd_0C_after_reset", g, 32'h0);
    chk("rd_0C_err", 32'(ge), 32'h0);
    idle();

    // Full write then single-lane write merge.
    xfer(0, 8'h04, 1'b1, 32'hDEADBEEF, 4'b1111, 3'b001, 1'b0, g, ge); idle();
    xfer(0, 8'h04, 1'b1, 32'h000000AA, 4'b0001, 3'b001, 1'b1, g, ge); idle();
    xfer(0, 8'h04, 1'b0, 32'h0, 4'h0, 3'b000, 1'b0, g, ge);
    chk("strobe_merge", g, 32'hDEADBEAA);
    idle();

    // Out-of-range index.
    xfer(0, 8'h40, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b001, 1'b0, g, ge);
    chk("oor_err", 32'(ge), 32'h1);
    idle();
    xfer(0, 8'h00, 1'b0, 32'h0, 4'hF, 3'b001, 1'b0, g, ge);
    chk("rd_00_after_oor", g, 32'h0);
    chk("rd_00_err", 32'(ge), 32'h0);
    idle();

    // Unprivileged write rejected.
    xfer(0, 8'h08, 1'b1, 32'h12345678, 4'hF, 3'b000, 1'b0, g, ge);
    chk("unpriv_err", 32'(ge), 32'h1);
    idle();
    xfer(0, 8'h08, 1'b0, 32'h0, 4'hF, 3'b000, 1'b0, g, ge);
    chk("rd_08_unchanged", g, 32'h0);
    idle();

    // Zero wait states, back-to-back write then read of 0x10.
    xfer(1, 8'h10, 1'b1, 32'hCAFEF00D, 4'hF, 3'b001, 1'b0, g, ge);
    xfer(1, 8'h10, 1'b0, 32'h0, 4'h0, 3'b000, 1'b0, g, ge);
    chk("b2b_ws0_read", g, 32'hCAFEF00D);
    idle();

    // Protocol oddities: penable without setup, abandoned setup, restarted setup.
    cyc(); sel[0] = 1'b1; en[0] = 1'b1;
    idle();
    partial(0, 8'h14, 1'b1, 32'h11111111, 4'hF, 3'b001);
    idle();
    partial(0, 8'h18, 1'b1, 32'h22222222, 4'hF, 3'b001);
    xfer(0, 8'h1C, 1'b1, 32'h33333333, 4'hF, 3'b001, 1'b0, g, ge); idle();
    xfer(0, 8'h14, 1'b0, 32'h0, 4'h0, 3'b001, 1'b0, g, ge);
    chk("abort_no_write", g, 32'h0);
    xfer(0, 8'h18, 1'b0, 32'h0, 4'h0, 3'b001, 1'b0, g, ge);
    chk("restart_drops_first", g, 32'h0);
    xfer(0, 8'h1C, 1'b0, 32'h0, 4'h0, 3'b001, 1'b0, g, ge);
    chk("restart_takes_second", g, 32'h33333333);
    idle();

    // Random traffic on both instances.
    prev_d = 0;
    for (int n = 0; n < 300; n++) begin
      rd_d = $urandom_range(0, 1);
      if (rd_d != prev_d || $urandom_range(0, 2) == 0) idle();
      prev_d = rd_d;
      ra = 8'($urandom_range(0, 79));
      rw = 1'($urandom);
      rp = 3'($urandom);
      rp[0] = ($urandom_range(0, 3) != 0);
      if (rd_d == 0 && $urandom_range(0, 5) == 0) begin
        partial(0, 8'($urandom_range(0, 79)), 1'b1, $urandom, 4'hF, 3'b001);
        if ($urandom_range(0, 1) == 1) idle();
      end
      xfer(rd_d, ra, rw, $urandom, 4'($urandom), rp, 1'($urandom), g, ge);
    end
    idle();

    // Reset asserted in the completion cycle of a write discards it.
    xfer(0, 8'h00, 1'b1, 32'h55AA1234, 4'hF, 3'b001, 1'b0, g, ge); idle();
    xfer(0, 8'h00, 1'b0, 32'h0, 4'h0, 3'b001, 1'b0, g, ge);
    chk("pre_reset_value", g, 32'h55AA1234);
    idle();
    partial(0, 8'h00, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b001);
    cyc(); en[0] = 1'b1;
    cyc();
    exp_rdy[0] = 1'b1;
    #2;
    presetn = 1'b0;
    exp_rdy[0] = 1'b0;
    clear_model();
    #1;
    chk("async_reset_pready", 32'(rdy[0]), 32'h0);
    cyc(); sel[0] = 1'b0; en[0] = 1'b0;
    cyc(); presetn = 1'b1;
    idle();
    xfer(0, 8'h00, 1'b0, 32'h0, 4'h0, 3'b001, 1'b0, g, ge);
    chk("post_reset_read", g, 32'h0);
    idle();
    idle();

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_regbank_completer.md
Name: apb_regbank_completer

Overview:
- APB completer (peripheral end) containing a bank of NUM_REGS word-wide read/write registers.
- Accepts transfers from the team's APB bridge, with programmable wait states, byte-strobe writes, and error responses for bad addresses and unprivileged writes.
- Serves as the default register target on the APB segment and as the reference completer for bridge verification.

Parameters:
- ADDR_WIDTH, 8, width of paddr
- DATA_WIDTH, 32, width of pwdata/prdata; must be a multiple of 8
- STRB_WIDTH, DATA_WIDTH/8, width of pstrb
- NUM_REGS, 16, number of registers; must be ≤ 2^(ADDR_WIDTH-2)
- WAIT_STATES, 1, access-phase cycles with pready=0 before completion (0..15)

Ports:
- pclk  input  1  APB clock
- presetn  input  1  active-low reset
- paddr  input  ADDR_WIDTH  byte address
- psel  input  1  completer select
- penable  input  1  access-phase indicator
- pwrite  input  1  1=write, 0=read
- pwdata  input  DATA_WIDTH  write data
- pstrb  input  STRB_WIDTH  write byte-lane enables
- pprot  input  3  protection; bit0=privileged
- prdata  output  DATA_WIDTH  read data
- pready  output  1  transfer completion
- pslverr  output  1  error response

Behaviour:
- Clock and reset: one clock, pclk. presetn is asynchronous, active-low.
- Reset values: pready=0, pslverr=0, prdata=0, all registers=0, FSM=IDLE, wait counter=0.
- All outputs are registered.
- FSM states:
  - IDLE: waits for psel=1 with penable=0 (setup). On setup, captures paddr/pwrite/pwdata/pstrb/pprot, loads counter=WAIT_STATES, moves to ACCESS.
  - ACCESS: while psel=1 and penable=1, decrements counter each cycle. pready=1 in exactly the cycle where the access phase has lasted WAIT_STATES+1 cycles.
  - DONE: the cycle after pready=1. pready returns to 0. If that cycle is a new setup (psel=1, penable=0), captures and enters ACCESS (back-to-back); otherwise goes to IDLE.
- Latency: completion occurs WAIT_STATES+1 cycles after the setup cycle. With WAIT_STATES=0, pready=1 in the first access cycle.
- Address decode:
  - index = paddr[ADDR_WIDTH-1:2]; paddr[1:0] are ignored.
  - index ≥ NUM_REGS -> error.
- Protection: a write with pprot[0]=0 -> error. Reads are always permitted.
- Error response: pslverr=1 only in the pready=1 cycle, otherwise 0. No register changes. prdata=0.
- Write:
  - Committed at the clock edge ending the pready=1 cycle.
  - Byte lane i is updated only when pstrb[i]=1.
  - pstrb=0 performs no update and gives no error.
- Read:
  - prdata = register value, valid only in the pready=1 cycle; 0 in all other cycles.
  - pstrb is ignored.
  - A read in the cycle after a write to the same register returns the new value.
- Input stability: paddr/pwrite/pwdata/pstrb/pprot are used only as captured in the setup cycle. Changes during the access phase are ignored.
- Protocol violations:
  - psel dropping in ACCESS before completion: FSM -> IDLE, no write, pready/pslverr stay 0.
  - penable=1 while in IDLE: ignored.
  - psel=1 and penable=0 while in ACCESS: treated as a fresh setup, recaptures inputs, reloads counter.
- Reset mid-transfer: all outputs clear immediately and asynchronously. A pending write is discarded.

Test Plan:
- Reset, then read index 3 (paddr=0x0C), WAIT_STATES=1 -> pready=1 in the 2nd access cycle, prdata=0x0000_0000, pslverr=0.
- Write 0xDEADBEEF to paddr=0x04 with pstrb=4'b1111, pprot=3'b001, then write 0x0000_00AA with pstrb=4'b0001 -> read of 0x04 returns 0xDEADBEAA.
- Write to paddr=0x40 (index 16 ≥ NUM_REGS) -> pslverr=1 coincident with pready. A subsequent read of 0x00 returns 0x0, pslverr=0.
- Write 0x12345678 to 0x08 with pprot=3'b000 -> pslverr=1, and a read of 0x08 returns the prior value (0x0).
- WAIT_STATES=0, back-to-back write then read of 0x10 with the next setup in the DONE cycle -> pready high on alternate cycles, read returns the written data.
- Deassert presetn during the access phase of a write to 0x00 -> pready=0 immediately, and after reset a read of 0x00 returns 0x0.
